// File: rtl/pipe_shift_unit_if.sv
// pipe_shift_unit_if: handshake bundle for pipe_shift_unit.
//   in_*  : operation request (valid/ready, operand, amount, op, tag)
//   out_* : result (valid/ready, data, tag, zero flag, reserved-op flag)
// master : the side that issues operations and consumes results
// slave  : the shifter itself
interface pipe_shift_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );
endinterface

// File: rtl/pipe_shift_unit.sv
// pipe_shift_unit: pipelined barrel shifter / rotator (SLL, SRL, SRA, ROL, ROR).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all valid bits and outputs
//   bus   : pipe_shift_unit_if.slave, request and result handshakes
// LOG2W mux levels are spread over PIPE register stages; level j lives in
// stage (j*PIPE)/LOG2W. One shared advance signal moves the whole pipe.
module pipe_shift_unit #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_shift_unit_if.slave  bus
);
  localparam int LOG2W = $clog2(WIDTH);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       op;
    logic [LOG2W-1:0] amt;   // low amount bits; levels consume them in order
    logic             over;  // amount >= WIDTH, resolved in the last stage
    logic [TAG_W-1:0] tag;
    logic             sign;  // in_a MSB, the SRA fill bit
  } stage_t;

  stage_t [PIPE-1:0] stg_q, stg_d;
  logic   [PIPE-1:0] vld_q, vld_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic              adv;

  stage_t            in_st;
  stage_t [PIPE:0]   src;      // src[s] feeds stage s; src[0] is the input port
  logic   [PIPE:0]   vld_src;

  // One mux level: shift/rotate by sh. Reserved ops pass the data through.
  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                  input logic [2:0] op,
                                                  input logic sgn,
                                                  input int sh);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (op)
      OP_SLL:  shift_lvl = d << sh;
      OP_SRL:  shift_lvl = d >> sh;
      OP_SRA:  shift_lvl = (d >> sh) | fill;
      OP_ROL:  shift_lvl = (d << sh) | (d >> (WIDTH - sh));
      OP_ROR:  shift_lvl = (d >> sh) | (d << (WIDTH - sh));
      default: shift_lvl = d;
    endcase
  endfunction

  // Bubbles are not squeezed out: only the output stage gates the pipe.
  assign adv = ~vld_q[PIPE-1] | bus.out_ready;

  always_comb begin
    in_st      = '0;
    in_st.data = bus.in_a;
    in_st.op   = bus.in_op;
    in_st.amt  = bus.in_b[LOG2W-1:0];
    in_st.over = |bus.in_b[WIDTH-1:LOG2W];
    in_st.tag  = bus.in_tag;
    in_st.sign = bus.in_a[WIDTH-1];
  end

  assign src     = {stg_q, in_st};
  assign vld_src = {vld_q, bus.in_valid & adv};

  always_comb begin
    stage_t cur;
    cur    = '0;
    stg_d  = stg_q;
    vld_d  = vld_q;
    zero_d = zero_q;
    err_d  = err_q;
    for (int s = 0; s < PIPE; s++) begin
      cur = src[s];
      for (int j = 0; j < LOG2W; j++) begin
        if (((j * PIPE) / LOG2W) == s && cur.amt[j])
          cur.data = shift_lvl(cur.data, cur.op, cur.sign, 1 << j);
      end
      if (s == PIPE - 1) begin
        // Over-range shifts saturate; rotates already wrapped mod WIDTH.
        if (cur.over) begin
          case (cur.op)
            OP_SLL, OP_SRL: cur.data = '0;
            OP_SRA:         cur.data = {WIDTH{cur.sign}};
            default:        cur.data = cur.data;
          endcase
        end
        if (adv) begin
          zero_d = (cur.data == '0);
          err_d  = (cur.op > OP_ROR);
        end
      end
      if (adv) begin
        stg_d[s] = cur;
        vld_d[s] = vld_src[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q  <= '0;
      vld_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      vld_q  <= vld_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[PIPE-1];
  assign bus.out_data  = stg_q[PIPE-1].data;
  assign bus.out_tag   = stg_q[PIPE-1].tag;
  assign bus.out_zero  = zero_q;
  assign bus.out_err   = err_q;

  // Past-the-end source slot only exists to keep the concatenation uniform.
  logic unused_tail;
  assign unused_tail = ^{src[PIPE], vld_src[PIPE]};
endmodule

// File: tb/tb_pipe_shift_unit.sv
module tb_pipe_shift_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_shift_unit_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  pipe_shift_unit_if #(.WIDTH(8),  .TAG_W(5)) b8a ();
  pipe_shift_unit_if #(.WIDTH(8),  .TAG_W(5)) b8b ();

  pipe_shift_unit #(.WIDTH(32), .PIPE(2), .TAG_W(5)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  pipe_shift_unit #(.WIDTH(8),  .PIPE(1), .TAG_W(5)) u8a (.clk(clk), .rst_n(rst_n), .bus(b8a));
  pipe_shift_unit #(.WIDTH(8),  .PIPE(3), .TAG_W(5)) u8b (.clk(clk), .rst_n(rst_n), .bus(b8b));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        zero;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8a[$];
  exp_t q8b[$];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec32_t;
  typedef struct { logic [2:0] op; logic [7:0]  a; logic [7:0]  b; logic [7:0]  e; } vec8_t;

  vec32_t v32 [17] = '{
    '{3'd2, 32'h80000000, 32'd4,        32'hF8000000},
    '{3'd0, 32'h80000000, 32'd32,       32'h00000000},
    '{3'd2, 32'h80000000, 32'h100,      32'hFFFFFFFF},
    '{3'd4, 32'h00000001, 32'd1,        32'h80000000},
    '{3'd3, 32'h00000001, 32'd33,       32'h00000002},
    '{3'd7, 32'h00000001, 32'd5,        32'h00000001},
    '{3'd1, 32'hF0000000, 32'd4,        32'h0F000000},
    '{3'd1, 32'h12345678, 32'd0,        32'h12345678},
    '{3'd2, 32'h7FFFFFFF, 32'h40,       32'h00000000},
    '{3'd3, 32'h80000001, 32'd4,        32'h00000018},
    '{3'd4, 32'h12345678, 32'hFFFFFFE8, 32'h78123456},
    '{3'd1, 32'h80000000, 32'd31,       32'h00000001},
    '{3'd2, 32'h80000000, 32'd31,       32'hFFFFFFFF},
    '{3'd5, 32'h00000000, 32'd3,        32'h00000000},
    '{3'd0, 32'hA5A5A5A5, 32'd16,       32'hA5A50000},
    '{3'd2, 32'h80000001, 32'd0,        32'h80000001},
    '{3'd3, 32'hDEADBEEF, 32'h20,       32'hDEADBEEF}
  };

  vec8_t v8 [16] = '{
    '{3'd0, 8'h81, 8'd1,   8'h02},
    '{3'd1, 8'h81, 8'd8,   8'h00},
    '{3'd1, 8'h81, 8'd3,   8'h10},
    '{3'd2, 8'h81, 8'd3,   8'hF0},
    '{3'd2, 8'h81, 8'd9,   8'hFF},
    '{3'd2, 8'h41, 8'd2,   8'h10},
    '{3'd3, 8'h81, 8'd1,   8'h03},
    '{3'd4, 8'h81, 8'd1,   8'hC0},
    '{3'd3, 8'h96, 8'h0B,  8'hB4},
    '{3'd4, 8'h96, 8'h0D,  8'hB4},
    '{3'd6, 8'h5A, 8'd2,   8'h5A},
    '{3'd0, 8'h5A, 8'd0,   8'h5A},
    '{3'd0, 8'h01, 8'd7,   8'h80},
    '{3'd1, 8'h80, 8'd7,   8'h01},
    '{3'd0, 8'h80, 8'h80,  8'h00},
    '{3'd4, 8'h00, 8'd3,   8'h00}
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic check_item(input string nm, input exp_t e, input logic [31:0] d,
                            input logic [4:0] t, input logic z, input logic er, input int pipe);
    chk({nm, " data"}, d, e.data);
    chk({nm, " tag"},  {27'd0, t}, {27'd0, e.tag});
    chk({nm, " zero"}, {31'd0, z}, {31'd0, e.zero});
    chk({nm, " err"},  {31'd0, er}, {31'd0, e.err});
    if (e.lat) chk({nm, " latency"}, cyc - e.acc, pipe);
  endtask

  // Pops one expectation per consumed result, on every DUT.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) flag($sformatf("w32 unexpected result tag %0d data %08h", b32.out_tag, b32.out_data));
        else check_item("w32", q32.pop_front(), b32.out_data, b32.out_tag, b32.out_zero, b32.out_err, 2);
      end
      if (b8a.out_valid && b8a.out_ready) begin
        if (q8a.size() == 0) flag($sformatf("w8p1 unexpected result tag %0d", b8a.out_tag));
        else check_item("w8p1", q8a.pop_front(), {24'd0, b8a.out_data}, b8a.out_tag, b8a.out_zero, b8a.out_err, 1);
      end
      if (b8b.out_valid && b8b.out_ready) begin
        if (q8b.size() == 0) flag($sformatf("w8p3 unexpected result tag %0d", b8b.out_tag));
        else check_item("w8p3", q8b.pop_front(), {24'd0, b8b.out_data}, b8b.out_tag, b8b.out_zero, b8b.out_err, 3);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] ed, input bit push, input bit lat);
    bit ok;
    exp_t e;
    b32.in_valid = 1'b1; b32.in_op = op; b32.in_a = a; b32.in_b = b; b32.in_tag = tag;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = b32.in_ready;
    end
    if (!ok) flag("w32 in_ready timeout");
    else if (push) begin
      e = '{data: ed, tag: tag, zero: (ed == 32'd0), err: (op >= 3'd5), acc: cyc, lat: lat};
      q32.push_back(e);
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] tag, input logic [7:0] ed);
    bit ok;
    exp_t e;
    b8a.in_valid = 1'b1; b8a.in_op = op; b8a.in_a = a; b8a.in_b = b; b8a.in_tag = tag;
    b8b.in_valid = 1'b1; b8b.in_op = op; b8b.in_a = a; b8b.in_b = b; b8b.in_tag = tag;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = b8a.in_ready && b8b.in_ready;
    end
    if (!ok) flag("w8 in_ready timeout");
    else begin
      e = '{data: {24'd0, ed}, tag: tag, zero: (ed == 8'd0), err: (op >= 3'd5), acc: cyc, lat: 1'b1};
      q8a.push_back(e);
      q8b.push_back(e);
    end
    @(posedge clk); #1;
    b8a.in_valid = 1'b0;
    b8b.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 60 && (q32.size() + q8a.size() + q8b.size()) != 0; n++) @(negedge clk);
    if ((q32.size() + q8a.size() + q8b.size()) != 0) begin
      flag($sformatf("%s: results missing w32=%0d w8p1=%0d w8p3=%0d", nm, q32.size(), q8a.size(), q8b.size()));
      q32.delete(); q8a.delete(); q8b.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    b32.in_valid = 0; b32.in_a = '0; b32.in_b = '0; b32.in_op = '0; b32.in_tag = '0; b32.out_ready = 0;
    b8a.in_valid = 0; b8a.in_a = '0; b8a.in_b = '0; b8a.in_op = '0; b8a.in_tag = '0; b8a.out_ready = 0;
    b8b.in_valid = 0; b8b.in_a = '0; b8b.in_b = '0; b8b.in_op = '0; b8b.in_tag = '0; b8b.out_ready = 0;
    fork monitor(); join_none

    // Reset state, with out_ready low so in_ready must come from out_valid=0.
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", {31'd0, b32.out_valid}, 32'd0);
    chk("reset out_data",  b32.out_data, 32'd0);
    chk("reset out_tag",   {27'd0, b32.out_tag}, 32'd0);
    chk("reset out_zero",  {31'd0, b32.out_zero}, 32'd0);
    chk("reset out_err",   {31'd0, b32.out_err}, 32'd0);
    chk("reset in_ready",  {31'd0, b32.in_ready}, 32'd1);
    chk("reset w8 valid",  {30'd0, b8a.out_valid, b8b.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b32.out_ready = 1; b8a.out_ready = 1; b8b.out_ready = 1;
    @(posedge clk); #1;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 17; i++) send32(v32[i].op, v32[i].a, v32[i].b, 5'(i), v32[i].e, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send8(v8[i].op, v8[i].a, v8[i].b, 5'(i), v8[i].e);
    drain("directed");

    // Back-pressure: six ops, output stalled for 4 cycles after the first result.
    fork
      begin
        for (int t = 0; t < 6; t++) send32(3'd0, 32'd1, 32'(t), 5'(t), 32'd1 << t, 1'b1, 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = b32.out_valid;
        end
        if (!seen) flag("stall: first result timeout");
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall out_valid", {31'd0, b32.out_valid}, 32'd1);
          chk("stall out_data",  b32.out_data, 32'd2);
          chk("stall out_tag",   {27'd0, b32.out_tag}, 32'd1);
          chk("stall in_ready",  {31'd0, b32.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        b32.out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset with two ops in flight; neither may ever be reported.
    send32(3'd0, 32'd3, 32'd1, 5'd30, 32'd6, 1'b0, 1'b0);
    send32(3'd2, 32'h80000000, 32'd2, 5'd31, 32'hE0000000, 1'b0, 1'b0);
    b32.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'd0, b32.out_valid}, 32'd0);
    chk("midreset out_data",  b32.out_data, 32'd0);
    chk("midreset out_tag",   {27'd0, b32.out_tag}, 32'd0);
    chk("midreset in_ready",  {31'd0, b32.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    send32(3'd0, 32'd1, 32'd31, 5'd17, 32'h80000000, 1'b1, 1'b1);
    drain("post-reset");
    repeat (6) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_shift_unit.md
# pipe_shift_unit

Parametrised, pipelined barrel shifter and rotator for the datapath. It supersedes the single-cycle 32-bit SLL/SRL/SRA shifters with five features: a configurable word width, a mode select that adds rotates, a configurable pipeline depth, valid/ready flow control and a pass-through tag. It sits between the operand-fetch stage and writeback, alongside the ALU, and serves shift-class instructions.

## Interface
Parameters:
- WIDTH, default 32: data width. Must be a power of 2 and at least 8. LOG2W = log2(WIDTH) is derived.
- PIPE, default 2: number of register stages, in the range 1..LOG2W. This equals the latency in cycles.
- TAG_W, default 5: width of the tag carried alongside each operation (e.g. destination register).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit can accept the input this cycle.
- in_a  in  WIDTH  operand to shift.
- in_b  in  WIDTH  shift amount. The full word is significant (see the over-limit rules).
- in_op  in  3  operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 reserved.
- in_tag  in  TAG_W  tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  asserted when out_data == 0.
- out_err  out  1  asserted when in_op was reserved.

## Operation
- Shift logic is LOG2W mux levels. Level j shifts by 2^j when amt[j]=1.
- Level j is placed in pipeline stage floor(j*PIPE/LOG2W). Each stage ends in a register holding data, op, the remaining amount bits, the over-limit flag, the tag, sign (in_a[WIDTH-1]) and a valid bit.
- Fill value per mode:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: the latched in_a[WIDTH-1] enters at the MSB.
  - ROL/ROR: bits wrap around.
- Over-limit handling is computed in stage 0 and carried through the pipeline. over = |in_b[WIDTH-1:LOG2W].
  - SLL/SRL with over=1: result is all zeros.
  - SRA with over=1: result is the sign bit replicated across the word.
  - ROL/ROR: in_b[WIDTH-1:LOG2W] is ignored and the amount is taken mod WIDTH.
- Amount 0 in any valid mode returns in_a unchanged.
- Reserved op: out_data = in_a, out_err = 1, and out_zero is computed normally.
- out_zero and out_err are registered together with out_data in the final stage.

Flow control:
- The whole pipeline shares one advance signal: adv = !out_valid | out_ready.
- in_ready = adv. This is combinational from out_ready and does not depend on in_valid.
- An input is accepted when in_valid & in_ready.
- When adv=1, every stage register loads from its predecessor. Stage 0 loads in_valid & in_ready as its valid bit.
- When adv=0, all stages hold their contents.
- Bubbles are not collapsed. A stalled pipeline with empty middle stages stays stalled until out_ready rises.
- out_* fields are stable while out_valid=1 and out_ready=0.
- No state machine beyond the per-stage valid bits.

## Timing
- Latency is exactly PIPE cycles, measured from the accepting edge to out_valid high, when there is no back-pressure.
- Throughput is 1 operation per cycle while out_ready=1.
- Reset (rst_n=0), asynchronous and immediate: all valid bits clear, so out_valid=0, and out_data, out_tag, out_zero and out_err are 0. in_ready=1 while in reset, because out_valid=0.
- Reset in the middle of an operation discards all in-flight operations. The first result after rst_n rises comes from an input accepted after reset, PIPE cycles later.
- When a result is consumed and a new input is accepted in the same cycle, both happen on the same edge. There is no gap in output.
- Ordering: results leave in acceptance order. Tags are never reordered.

## Test plan
- Default params, SRA: in_a=0x80000000, in_b=4 → out_data=0xF8000000 exactly 2 cycles later, out_zero=0.
- Over-limit shifts, in_a=0x80000000:
  - SLL with in_b=32 → 0x00000000, out_zero=1.
  - SRA with in_b=0x100 → 0xFFFFFFFF.
- Rotates, in_a=0x00000001:
  - ROR with in_b=1 → 0x80000000.
  - ROL with in_b=33 → 0x00000002.
  - Reserved op 111 → out_data=0x00000001, out_err=1.
- Back-pressure: stream 6 ops with tags 0..5 while holding out_ready=0 for 4 cycles after the first result.
  - out_data and out_tag hold while stalled; in_ready=0 while stalled.
  - All 6 results emerge in tag order with none lost or duplicated.
- Reset mid-stream: drop rst_n for one cycle while 2 ops are in flight.
  - Outputs go to 0 immediately; neither op ever appears.
  - A new SLL in_a=0x1, in_b=31 → 0x80000000.
- Parametric sweep with WIDTH=8 and PIPE in {1,3}: random in_a/in_b/op compared against a reference model.
  - Latency equals PIPE.
  - in_b=8 with SRL → 0.
